rob_commit_unit: RTL and testbench
==================================

Name: rob_commit_unit

Overview:
- Reorder-buffer storage plus the in-order retire side of the Tomasulo core.
- The issue stage writes entries at the tail through the allocate port. The CDB marks entries complete by tag.
- This block reads the head entry and retires it to the architectural register file and RAT, one instruction per cycle, in program order.
- It is the reader/consumer end of the ROB protocol that issue drives.

Parameters:
- ROB_DEPTH, 128, number of ROB entries; must be a power of 2.
- TAG_W, 7, ROB tag width; log2(ROB_DEPTH).
- DATA_W, 32, result width.
- REG_W, 5, architectural register address width.
- IDX_W, 11, program-order instruction index width.

Ports:
- clock  in  1  single core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  issue requests a new entry this cycle.
- alloc_ready  out  1  entry available; equals !rob_full.
- alloc_dest  in  REG_W  destination register of the issuing instruction.
- alloc_index  in  IDX_W  instruction index of the issuing instruction.
- alloc_tag  out  TAG_W  current tail; this is the tag given to an accepted allocation.
- cdb_valid  in  1  CDB broadcast present.
- cdb_tag  in  TAG_W  ROB tag being completed.
- cdb_value  in  DATA_W  result value.
- flush  in  1  synchronous squash of all entries.
- commit_valid  out  1  one instruction retired (one-cycle pulse per retire).
- commit_rf_we  out  1  commit_valid && commit_dest != 0.
- commit_dest  out  REG_W  register written by the retiring instruction.
- commit_value  out  DATA_W  value written.
- commit_tag  out  TAG_W  ROB tag retired; the RAT clears its valid bit only if its stored tag matches.
- commit_index  out  IDX_W  index of the retired instruction.
- rob_empty  out  1  count == 0.
- rob_full  out  1  count == ROB_DEPTH.
- rob_count  out  TAG_W+1  number of occupied entries.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - head = tail = count = 0; all busy and done bits = 0.
  - All commit_* outputs = 0; rob_empty = 1, rob_full = 0, alloc_tag = 0.
- Per-entry state: busy, done, dest, value, index.
- Allocate:
  - Fires when alloc_valid && alloc_ready.
  - Entry[tail] gets busy=1, done=0, dest and index from the alloc port; tail = tail+1 mod ROB_DEPTH.
- CDB:
  - Fires when cdb_valid and entry[cdb_tag] has busy=1.
  - Sets done=1 and value=cdb_value.
  - A broadcast to a non-busy entry is ignored.
  - A duplicate broadcast overwrites value (last wins).
- Retire:
  - Fires at an edge where entry[head] has busy=1 and done=1.
  - Clears busy and done of entry[head]; head = head+1 mod ROB_DEPTH.
  - Registers commit_* from that entry; commit_valid is high for the following cycle only.
  - No retire means commit_valid=0 the next cycle. Other commit_* outputs hold their last values.
- Latency:
  - CDB write in cycle N sets done at the end of N.
  - Earliest retire is at the end of N+1; commit_valid is visible in N+2.
  - There is no CDB-to-commit bypass.
- Throughput: at most one allocate, one CDB write and one retire per cycle, all concurrent.
- Count: count = count + alloc − retire (net 0 when both fire).
- alloc_ready: derived from the registered count. When full, allocation is refused even if a retire happens the same cycle.
- Single-entry case: entry allocated and retired in the same cycle cannot happen, because retire needs done=1, which is set at least one edge later.
- Wrap-around: head and tail wrap modulo ROB_DEPTH; full versus empty is distinguished only by count.
- Flush:
  - Synchronous; takes priority over allocate, CDB and retire in the same cycle.
  - Clears all busy and done bits; head = tail = count = 0.
  - commit_valid = 0 in the next cycle.
- Reset asserted mid-operation: immediate asynchronous clear as above. In-flight commits are lost.

Decomposition:
- Shared package rob_pkg:
  - TAG_W, DATA_W, REG_W, IDX_W, ROB_DEPTH.
  - rob_entry_t typedef (busy, done, dest, value, index).
  - Also used by the issue stage and RS.
- One sub-module, rob_ptr_ctrl:
  - Owns head, tail and count.
  - Produces full, empty and alloc_ready from the alloc_fire, retire_fire and flush inputs.
- Entry array and retire logic stay in rob_commit_unit.

Test Plan:
- Reset, then allocate dest=5 idx=0 (tag 0); CDB tag 0 value 0x1234 in cycle N -> commit_valid=1 in N+2 with dest=5, value=0x1234, tag=0, rf_we=1.
- Allocate tags 0,1,2; CDB completes 2, then 1, then 0 -> retires come out in order 0,1,2 on consecutive cycles after tag 0 completes; nothing retires before that.
- Allocate 128 entries -> rob_full=1, alloc_ready=0, a 129th request is not accepted. Then retire 1 with alloc_valid held in the same cycle -> no allocation that cycle, one the next, and the tail wraps to tag 0.
- Allocate with dest=0, complete it -> commit_valid=1, commit_rf_we=0.
- Allocate 3, complete 1, assert flush together with a CDB and an alloc -> count=0, empty=1, no commit_valid next cycle, the next allocation gets tag 0.
- Assert reset_n=0 asynchronously mid-stream with 10 entries live -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/rob_pkg.sv
// Reorder-buffer shared definitions.
// Used by issue, reservation stations and the commit unit.
package rob_pkg;

  localparam int ROB_DEPTH = 128;
  localparam int TAG_W     = $clog2(ROB_DEPTH);
  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;
  localparam int IDX_W     = 11;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
    logic [IDX_W-1:0]  index;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// ROB head/tail/count bookkeeping.
// Full and empty are told apart by count alone.
module rob_ptr_ctrl
  import rob_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alloc_fire,
  input  logic             retire_fire,
  input  logic             flush,
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail,
  output logic [TAG_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             alloc_ready
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire)
        tail <= tail + 1'b1;
      if (retire_fire)
        head <= head + 1'b1;
      count <= count
             + (TAG_W+1)'(alloc_fire)
             - (TAG_W+1)'(retire_fire);
    end
  end

  assign full        = (count == (TAG_W+1)'(ROB_DEPTH));
  assign empty       = (count == '0);
  assign alloc_ready = !full;

endmodule

// File: rtl/rob_commit_unit.sv
// ROB entry storage and in-order retire port.
// Retires one done head entry per cycle into registered commit outputs.
module rob_commit_unit
  import rob_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [REG_W-1:0]  alloc_dest,
  input  logic [IDX_W-1:0]  alloc_index,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              flush,
  output logic              commit_valid,
  output logic              commit_rf_we,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_value,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [IDX_W-1:0]  commit_index,
  output logic              rob_empty,
  output logic              rob_full,
  output logic [TAG_W:0]    rob_count
);

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic             ready;
  logic             alloc_fire;
  logic             cdb_fire;
  logic             retire_fire;
  rob_entry_t       rob_q [ROB_DEPTH];
  rob_entry_t       head_e;

  assign head_e      = rob_q[head];
  assign alloc_fire  = alloc_valid && ready && !flush;
  assign cdb_fire    = cdb_valid && rob_q[cdb_tag].busy;
  assign retire_fire = head_e.busy && head_e.done && !flush;

  rob_ptr_ctrl u_ptr (
    .clock       (clock),
    .reset_n     (reset_n),
    .alloc_fire  (alloc_fire),
    .retire_fire (retire_fire),
    .flush       (flush),
    .head        (head),
    .tail        (tail),
    .count       (rob_count),
    .full        (rob_full),
    .empty       (rob_empty),
    .alloc_ready (ready)
  );

  // Tail is never busy when allocating, so only CDB and retire can
  // meet on one entry; retire's clear of busy/done must win there.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROB_DEPTH; i++)
        rob_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob_q[i].busy <= 1'b0;
        rob_q[i].done <= 1'b0;
      end
    end else begin
      if (alloc_fire) begin
        rob_q[tail].busy  <= 1'b1;
        rob_q[tail].done  <= 1'b0;
        rob_q[tail].dest  <= alloc_dest;
        rob_q[tail].value <= '0;
        rob_q[tail].index <= alloc_index;
      end
      if (cdb_fire) begin
        rob_q[cdb_tag].done  <= 1'b1;
        rob_q[cdb_tag].value <= cdb_value;
      end
      if (retire_fire) begin
        rob_q[head].busy <= 1'b0;
        rob_q[head].done <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      commit_valid <= 1'b0;
      commit_rf_we <= 1'b0;
      commit_dest  <= '0;
      commit_value <= '0;
      commit_tag   <= '0;
      commit_index <= '0;
    end else begin
      commit_valid <= retire_fire;
      commit_rf_we <= retire_fire && (head_e.dest != '0);
      if (retire_fire) begin
        commit_dest  <= head_e.dest;
        commit_value <= head_e.value;
        commit_tag   <= head;
        commit_index <= head_e.index;
      end
    end
  end

  assign alloc_ready = ready;
  assign alloc_tag   = tail;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboard bench for rob_commit_unit.
// Reference ROB is a program-order queue of live instructions.
module tb_rob_commit_unit;
  import rob_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              alloc_valid = 1'b0;
  logic              alloc_ready;
  logic [REG_W-1:0]  alloc_dest = '0;
  logic [IDX_W-1:0]  alloc_index = '0;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic [DATA_W-1:0] cdb_value = '0;
  logic              flush = 1'b0;
  logic              commit_valid;
  logic              commit_rf_we;
  logic [REG_W-1:0]  commit_dest;
  logic [DATA_W-1:0] commit_value;
  logic [TAG_W-1:0]  commit_tag;
  logic [IDX_W-1:0]  commit_index;
  logic              rob_empty;
  logic              rob_full;
  logic [TAG_W:0]    rob_count;

  rob_commit_unit dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_dest   (alloc_dest),
    .alloc_index  (alloc_index),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .flush        (flush),
    .commit_valid (commit_valid),
    .commit_rf_we (commit_rf_we),
    .commit_dest  (commit_dest),
    .commit_value (commit_value),
    .commit_tag   (commit_tag),
    .commit_index (commit_index),
    .rob_empty    (rob_empty),
    .rob_full     (rob_full),
    .rob_count    (rob_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [REG_W-1:0]  dest;
    logic [IDX_W-1:0]  idx;
    bit                done;
    logic [DATA_W-1:0] val;
  } m_ent_t;

  typedef struct {
    int                cyc;
    logic [TAG_W-1:0]  tag;
    logic [REG_W-1:0]  dest;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] val;
  } exp_t;

  m_ent_t           m_rob[$];
  exp_t             exp_q[$];
  logic [TAG_W-1:0] m_tail = '0;
  int               cyc = 0;
  int               n_cmp = 0;
  int               n_bad = 0;
  bit               mon_on = 1'b0;
  logic [IDX_W-1:0] next_idx = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_rob.delete();
    exp_q.delete();
    m_tail = '0;
  endtask

  // Applies the rules for the edge that just happened to the queue model.
  task automatic model_edge();
    bit     ret;
    bit     acc;
    m_ent_t e;
    exp_t   x;
    if (!reset_n || flush) begin
      model_clear();
      return;
    end
    ret = (m_rob.size() > 0) && m_rob[0].done;
    acc = alloc_valid && (m_rob.size() < ROB_DEPTH);
    if (ret) begin
      x.cyc  = cyc;
      x.tag  = m_rob[0].tag;
      x.dest = m_rob[0].dest;
      x.idx  = m_rob[0].idx;
      x.val  = m_rob[0].val;
      exp_q.push_back(x);
    end
    if (cdb_valid)
      foreach (m_rob[i])
        if (m_rob[i].tag == cdb_tag) begin
          m_rob[i].done = 1'b1;
          m_rob[i].val  = cdb_value;
        end
    if (ret) void'(m_rob.pop_front());
    if (acc) begin
      e.tag  = m_tail;
      e.dest = alloc_dest;
      e.idx  = alloc_index;
      e.done = 1'b0;
      e.val  = '0;
      m_rob.push_back(e);
      m_tail = m_tail + 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    model_edge();
  endtask

  task automatic drv(bit av, logic [REG_W-1:0] d, logic [IDX_W-1:0] ix,
                     bit cv, logic [TAG_W-1:0] ct,
                     logic [DATA_W-1:0] cval, bit fl);
    alloc_valid = av;
    alloc_dest  = d;
    alloc_index = ix;
    cdb_valid   = cv;
    cdb_tag     = ct;
    cdb_value   = cval;
    flush       = fl;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drv(0, '0, '0, 0, '0, '0, 0);
  endtask

  // Monitor: pops an expected retire whenever one is due this cycle.
  always @(negedge clock) begin
    if (mon_on) begin
      bit   want;
      exp_t e;
      want = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("commit_valid", commit_valid, want);
      if (want) begin
        e = exp_q.pop_front();
        if (commit_valid) begin
          chk("commit_tag", commit_tag, e.tag);
          chk("commit_dest", commit_dest, e.dest);
          chk("commit_value", commit_value, e.val);
          chk("commit_index", commit_index, e.idx);
          chk("commit_rf_we", commit_rf_we, e.dest != '0);
        end
      end else begin
        chk("rf_we_idle", commit_rf_we, 0);
      end
      chk("rob_count", rob_count, m_rob.size());
      chk("rob_empty", rob_empty, m_rob.size() == 0);
      chk("rob_full", rob_full, m_rob.size() == ROB_DEPTH);
      chk("alloc_ready", alloc_ready, m_rob.size() < ROB_DEPTH);
      chk("alloc_tag", alloc_tag, m_tail);
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_empty", rob_empty, 1);
    chk("rst_full", rob_full, 0);
    chk("rst_alloc_tag", alloc_tag, 0);
    reset_n = 1'b1;
    model_clear();
    mon_on = 1'b1;

    // Basic allocate -> complete -> retire latency
    drv(1, 5'd5, 11'd0, 0, '0, '0, 0);
    drv(0, '0, '0, 1, 7'd0, 32'h1234, 0);
    chk("t1_n1_valid", commit_valid, 0);
    idle(1);
    chk("t1_n2_valid", commit_valid, 1);
    chk("t1_dest", commit_dest, 5);
    chk("t1_value", commit_value, 32'h1234);
    chk("t1_tag", commit_tag, 0);
    chk("t1_rf_we", commit_rf_we, 1);
    idle(2);

    // Out-of-order completion, in-order retire
    drv(0, '0, '0, 0, '0, '0, 1);
    for (int i = 0; i < 3; i++)
      drv(1, 5'(i + 1), 11'(i + 1), 0, '0, '0, 0);
    drv(0, '0, '0, 1, 7'd2, 32'hc2, 0);
    drv(0, '0, '0, 1, 7'd1, 32'hc1, 0);
    drv(0, '0, '0, 1, 7'd0, 32'hc0, 0);
    idle(5);

    // dest 0 retires without RF write
    drv(1, 5'd0, 11'd9, 0, '0, '0, 0);
    drv(0, '0, '0, 1, 7'd3, 32'hdead, 0);
    idle(3);

    // Fill, refuse, retire-with-held-alloc, wrap
    drv(0, '0, '0, 0, '0, '0, 1);
    for (int i = 0; i < ROB_DEPTH; i++)
      drv(1, 5'(i + 1), 11'(i), 0, '0, '0, 0);
    chk("full_flag", rob_full, 1);
    chk("full_ready", alloc_ready, 0);
    chk("full_count", rob_count, 128);
    chk("full_tail", alloc_tag, 0);
    drv(1, 5'd7, 11'd200, 0, '0, '0, 0);
    chk("full_refuse", rob_count, 128);
    drv(1, 5'd7, 11'd201, 1, 7'd0, 32'h77, 0);
    drv(1, 5'd7, 11'd202, 0, '0, '0, 0);
    chk("full_ret_count", rob_count, 127);
    chk("full_ret_tag", alloc_tag, 0);
    drv(1, 5'd7, 11'd203, 0, '0, '0, 0);
    chk("wrap_count", rob_count, 128);
    chk("wrap_tag", alloc_tag, 1);
    drv(0, '0, '0, 0, '0, '0, 1);

    // Flush beats same-cycle alloc and CDB
    for (int i = 0; i < 3; i++)
      drv(1, 5'(i + 4), 11'(i), 0, '0, '0, 0);
    drv(0, '0, '0, 1, 7'd1, 32'h11, 0);
    drv(1, 5'd9, 11'd9, 1, 7'd0, 32'h22, 1);
    chk("flush_count", rob_count, 0);
    chk("flush_empty", rob_empty, 1);
    chk("flush_cv", commit_valid, 0);
    chk("flush_tag", alloc_tag, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit               av, cv, fl;
      logic [TAG_W-1:0] ct;
      av = ($urandom_range(9) < 6);
      cv = ($urandom_range(1) == 1);
      fl = ($urandom_range(199) == 0);
      if (m_rob.size() > 0 && $urandom_range(3) != 0)
        ct = m_rob[$urandom_range(m_rob.size() - 1)].tag;
      else
        ct = TAG_W'($urandom);
      drv(av, REG_W'($urandom_range(31)), next_idx, cv, ct, $urandom, fl);
      if (av) next_idx = next_idx + 1'b1;
    end

    // Asynchronous reset with live entries and a commit in flight
    drv(0, '0, '0, 0, '0, '0, 1);
    for (int i = 0; i < 10; i++)
      drv(1, 5'(i + 1), 11'(i), 0, '0, '0, 0);
    drv(0, '0, '0, 1, 7'd0, 32'h55, 0);
    idle(1);
    chk("pre_rst_cv", commit_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_cv", commit_valid, 0);
    chk("arst_we", commit_rf_we, 0);
    chk("arst_dest", commit_dest, 0);
    chk("arst_value", commit_value, 0);
    chk("arst_count", rob_count, 0);
    chk("arst_empty", rob_empty, 1);
    chk("arst_tag", alloc_tag, 0);
    model_clear();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++)
      drv(1, 5'(i + 2), 11'(i), 0, '0, '0, 0);
    drv(0, '0, '0, 1, 7'd0, 32'h99, 0);
    idle(3);

    drv(0, '0, '0, 0, '0, '0, 1);
    idle(2);
    chk("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
